// File: rtl/mpp_tx_scheduler.sv
// Transmit scheduler for the MPP tail/hover waveform generator: arbitrates beacon
// bursts and digital-LF frames, times them in waveform periods and inserts guard gaps.
module mpp_tx_scheduler #(
   parameter int BEACON_PERIOD = 39,
   parameter int BEACON_REPS   = 4,
   parameter int DLF_PERIOD    = 22,
   parameter int DLF_BITS      = 8,
   parameter int GUARD_CYCLES  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                beacon_req,
   input  logic                dlf_req,
   input  logic [DLF_BITS-1:0] dlf_data,
   output logic                enable_beacon,
   output logic                enable_digital_lf,
   output logic                busy,
   output logic                beacon_done,
   output logic                dlf_done,
   output logic                dlf_overflow
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BEACON = 2'd1;
   localparam logic [1:0] S_DLF    = 2'd2;
   localparam logic [1:0] S_GUARD  = 2'd3;

   localparam int BEACON_LEN = BEACON_REPS * BEACON_PERIOD;
   localparam int MAX_BD     = (BEACON_LEN > DLF_PERIOD) ? BEACON_LEN : DLF_PERIOD;
   localparam int CYC_MAX    = (MAX_BD > GUARD_CYCLES) ? MAX_BD : GUARD_CYCLES;
   localparam int CW         = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int BW         = $clog2(DLF_BITS + 1);

   localparam logic [CW-1:0] BEACON_LAST = CW'(BEACON_LEN - 1);
   localparam logic [CW-1:0] DLF_LAST    = CW'(DLF_PERIOD - 1);
   localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYCLES - 1);
   localparam logic [BW-1:0] BITS_LAST   = BW'(DLF_BITS - 1);

   logic [1:0]          state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [BW-1:0]       bit_cnt, bit_n;
   logic [DLF_BITS-1:0] sr, sr_n;
   logic                beacon_pend, beacon_pend_n;
   logic                pend_vld, pend_vld_n;
   logic [DLF_BITS-1:0] pend_data, pend_data_n;
   logic                beacon_done_n, dlf_done_n, overflow_n;
   logic                dispatch;

   always_comb begin
      state_n       = state;
      cnt_n         = cnt + 1'b1;
      bit_n         = bit_cnt;
      sr_n          = sr;
      beacon_pend_n = beacon_pend;
      pend_vld_n    = pend_vld;
      pend_data_n   = pend_data;
      beacon_done_n = 1'b0;
      dlf_done_n    = 1'b0;
      overflow_n    = 1'b0;
      dispatch      = 1'b0;

      case (state)
         S_IDLE: dispatch = 1'b1;
         S_BEACON: begin
            if (cnt == BEACON_LAST) begin
               state_n       = S_GUARD;
               beacon_done_n = 1'b1;
            end
         end
         S_DLF: begin
            if (cnt == DLF_LAST) begin
               if (bit_cnt == BITS_LAST) begin
                  state_n    = S_GUARD;
                  dlf_done_n = 1'b1;
               end else begin
                  sr_n  = sr << 1;
                  bit_n = bit_cnt + 1'b1;
                  cnt_n = '0;
               end
            end
         end
         default: begin
            if (cnt == GUARD_LAST) begin
               state_n  = S_IDLE;
               dispatch = 1'b1;
            end
         end
      endcase

      // Capture first; a direct start below takes the request back out of storage.
      if (beacon_req && (state != S_BEACON))
         beacon_pend_n = 1'b1;
      if (dlf_req) begin
         if (pend_vld) begin
            overflow_n = 1'b1;
         end else begin
            pend_vld_n  = 1'b1;
            pend_data_n = dlf_data;
         end
      end

      if (dispatch) begin
         if (beacon_pend || beacon_req) begin
            state_n       = S_BEACON;
            beacon_pend_n = 1'b0;
         end else if (pend_vld) begin
            state_n    = S_DLF;
            sr_n       = pend_data;
            pend_vld_n = 1'b0;
         end else if (dlf_req) begin
            state_n    = S_DLF;
            sr_n       = dlf_data;
            pend_vld_n = 1'b0;
         end
      end

      if ((state_n != state) || (state_n == S_IDLE)) begin
         cnt_n = '0;
         bit_n = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         bit_cnt           <= '0;
         sr                <= '0;
         beacon_pend       <= 1'b0;
         pend_vld          <= 1'b0;
         pend_data         <= '0;
         enable_beacon     <= 1'b0;
         enable_digital_lf <= 1'b0;
         busy              <= 1'b0;
         beacon_done       <= 1'b0;
         dlf_done          <= 1'b0;
         dlf_overflow      <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         bit_cnt           <= bit_n;
         sr                <= sr_n;
         beacon_pend       <= beacon_pend_n;
         pend_vld          <= pend_vld_n;
         pend_data         <= pend_data_n;
         // Outputs are registered from the next state so they align with it.
         enable_beacon     <= (state_n == S_BEACON);
         enable_digital_lf <= (state_n == S_DLF) && sr_n[DLF_BITS-1];
         busy              <= (state_n != S_IDLE);
         beacon_done       <= beacon_done_n;
         dlf_done          <= dlf_done_n;
         dlf_overflow      <= overflow_n;
      end
   end

endmodule

// File: tb/tb_mpp_tx_scheduler.sv
// Scoreboard bench for mpp_tx_scheduler: per-cycle expected output words are queued
// when stimulus is applied and compared one per clock on the falling edge.
module tb_mpp_tx_scheduler;

   localparam int BL = 156;
   localparam int DP = 22;
   localparam int DB = 8;
   localparam int G  = 10;

   // Output word: {enable_beacon, enable_digital_lf, busy, beacon_done, dlf_done, dlf_overflow}
   localparam logic [5:0] W_BEACON = 6'b101000;
   localparam logic [5:0] W_BDONE  = 6'b001100;
   localparam logic [5:0] W_DDONE  = 6'b001010;
   localparam logic [5:0] W_GUARD  = 6'b001000;

   logic          clk = 1'b0;
   logic          rst;
   logic          beacon_req;
   logic          dlf_req;
   logic [DB-1:0] dlf_data;
   logic          enable_beacon, enable_digital_lf, busy;
   logic          beacon_done, dlf_done, dlf_overflow;

   logic [5:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   mpp_tx_scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .beacon_req        (beacon_req),
      .dlf_req           (dlf_req),
      .dlf_data          (dlf_data),
      .enable_beacon     (enable_beacon),
      .enable_digital_lf (enable_digital_lf),
      .busy              (busy),
      .beacon_done       (beacon_done),
      .dlf_done          (dlf_done),
      .dlf_overflow      (dlf_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b required %b", tag, $time, got, exp);
      end
   endtask

   task automatic push(input logic [5:0] w, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(w);
   endtask

   task automatic push_beacon();
      push(W_BEACON, BL);
      push(W_BDONE, 1);
      push(W_GUARD, G - 1);
   endtask

   task automatic push_dlf(input logic [DB-1:0] d);
      for (int b = DB - 1; b >= 0; b--) push({1'b0, d[b], 1'b1, 3'b000}, DP);
      push(W_DDONE, 1);
      push(W_GUARD, G - 1);
   endtask

   task automatic step();
      logic [5:0] e;
      @(posedge clk);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'b000000;
      chk("outs", {2'b00, enable_beacon, enable_digital_lf, busy,
                   beacon_done, dlf_done, dlf_overflow}, {2'b00, e});
      chk("mutex", {7'd0, enable_beacon & enable_digital_lf}, 8'd0);
   endtask

   task automatic drain(input int extra);
      while (exp_q.size() > 0) step();
      repeat (extra) step();
   endtask

   task automatic beacon_burst();
      beacon_req = 1'b1;
      push_beacon();
      step();
      beacon_req = 1'b0;
      drain(3);
   endtask

   initial begin
      rst        = 1'b1;
      beacon_req = 1'b0;
      dlf_req    = 1'b0;
      dlf_data   = '0;
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();

      // Single beacon burst
      beacon_burst();

      // Single DLF frame, on-off keyed MSB first
      dlf_req  = 1'b1;
      dlf_data = 8'b1010_0110;
      push_dlf(8'b1010_0110);
      step();
      dlf_req = 1'b0;
      drain(3);

      // Simultaneous requests: beacon first, DLF from the buffer after the guard
      beacon_req = 1'b1;
      dlf_req    = 1'b1;
      dlf_data   = 8'hFF;
      push_beacon();
      push_dlf(8'hFF);
      step();
      beacon_req = 1'b0;
      dlf_req    = 1'b0;
      drain(3);

      // Buffered request A accepted, B dropped with one overflow pulse
      dlf_req  = 1'b1;
      dlf_data = 8'h3C;
      push_dlf(8'h3C);
      step();
      dlf_req = 1'b0;
      repeat (4) step();
      dlf_req  = 1'b1;
      dlf_data = 8'h81;
      push_dlf(8'h81);
      step();
      dlf_req = 1'b0;
      repeat (5) step();
      dlf_req  = 1'b1;
      dlf_data = 8'hFF;
      exp_q[0] = exp_q[0] | 6'b000001;
      step();
      dlf_req = 1'b0;
      drain(3);

      // Repeated beacon_req during a burst merges into that burst
      beacon_req = 1'b1;
      push_beacon();
      step();
      beacon_req = 1'b0;
      for (int r = 0; r < 3; r++) begin
         repeat (20) step();
         beacon_req = 1'b1;
         step();
         beacon_req = 1'b0;
      end
      drain(3);

      // Reset mid-burst with a DLF request parked in the buffer
      beacon_req = 1'b1;
      push_beacon();
      step();
      beacon_req = 1'b0;
      repeat (10) step();
      dlf_req  = 1'b1;
      dlf_data = 8'hA5;
      step();
      dlf_req = 1'b0;
      repeat (38) step();
      rst = 1'b1;
      #1;
      chk("rst_async_eb", {7'd0, enable_beacon}, 8'd0);
      chk("rst_async_busy", {7'd0, busy}, 8'd0);
      exp_q.delete();
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();
      beacon_burst();

      // Beacon request during the guard after a frame starts right at guard end
      dlf_req  = 1'b1;
      dlf_data = 8'h01;
      push_dlf(8'h01);
      step();
      dlf_req = 1'b0;
      while (exp_q.size() > 5) step();
      beacon_req = 1'b1;
      push_beacon();
      step();
      beacon_req = 1'b0;
      drain(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
